multicycle_control: RTL and testbench

Moore-style control sequencer for the multicycle MIPS core. It replaces the single-cycle combinational control and drives one shared memory, the instruction register, the register file and the ALU over 3-5 cycles per instruction. It adds a memory wait handshake and a halt state for illegal opcodes. It sits between the instruction register (Opcode/Funct) and the datapath mux and enable signals.

---
 rtl/mc_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer:
// state encodings, opcode/funct values, ALUOp codes and mux selects.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_I_EXEC    = 4'd8;
  localparam logic [3:0] S_I_WB      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;
  localparam logic [3:0] S_JR        = 4'd13;
  localparam logic [3:0] S_TRAP      = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_ORI   = 2;
  localparam int ALU_ANDI  = 3;
  localparam int ALU_LUI   = 4;
  localparam int ALU_RTYPE = 7;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] SB_B   = 2'd0;
  localparam logic [1:0] SB_4   = 2'd1;
  localparam logic [1:0] SB_IMM = 2'd2;
  localparam logic [1:0] SB_BR  = 2'd3;

  localparam logic [1:0] PCS_ALU = 2'd0;
  localparam logic [1:0] PCS_OUT = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;
  localparam logic [1:0] PCS_A   = 2'd3;

endpackage

// File: rtl/multicycle_control.sv
// Moore control sequencer for the multicycle MIPS core with
// memory wait handshake and an illegal-opcode halt state.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Funct,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             PCSource,
  output logic                   Halted
);

  logic [3:0] state_q, state_d;
  logic is_rx, is_jr, is_ls, is_imm, is_br;
  logic is_j, is_jal;

  assign is_rx  = (Opcode == OP_RTYPE) && (Funct != FN_JR);
  assign is_jr  = (Opcode == OP_RTYPE) && (Funct == FN_JR);
  assign is_ls  = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign is_imm = (Opcode == OP_ADDI) || (Opcode == OP_ORI) ||
                  (Opcode == OP_ANDI) || (Opcode == OP_LUI);
  assign is_br  = (Opcode == OP_BEQ) || (Opcode == OP_BNE);
  assign is_j   = (Opcode == OP_J);
  assign is_jal = (Opcode == OP_JAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_ls:   state_d = S_MEM_ADDR;
          is_jr:   state_d = S_JR;
          is_rx:   state_d = S_R_EXEC;
          is_imm:  state_d = S_I_EXEC;
          is_br:   state_d = S_BRANCH;
          is_j:    state_d = S_JUMP;
          is_jal:  state_d = S_JAL;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:
        state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (MemReady) state_d = S_MEM_WB;
      S_MEM_WRITE: if (MemReady) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH,
      S_JUMP, S_JAL, S_JR:
        state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is held, including MemRead.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = RD_RT;
    MemtoReg = M2R_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SB_B;
    ALUOp    = ALUOP_WIDTH'(ALU_ADD);
    PCSource = PCS_ALU;
    Halted   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SB_4;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE:   ALUSrcB = SB_BR;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SB_IMM;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = M2R_MDR;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_WIDTH'(ALU_RTYPE);
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = RD_RD;
        end
        S_I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SB_IMM;
          unique case (Opcode)
            OP_ORI:  ALUOp = ALUOP_WIDTH'(ALU_ORI);
            OP_ANDI: ALUOp = ALUOP_WIDTH'(ALU_ANDI);
            OP_LUI:  ALUOp = ALUOP_WIDTH'(ALU_LUI);
            default: ALUOp = ALUOP_WIDTH'(ALU_ADD);
          endcase
        end
        S_I_WB:     RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_WIDTH'(ALU_SUB);
          PCSource = PCS_OUT;
          PCWrite  = ((Opcode == OP_BEQ) && Zero) ||
                     ((Opcode == OP_BNE) && !Zero);
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCS_JMP;
        end
        S_JAL: begin
          PCWrite  = 1'b1;
          PCSource = PCS_JMP;
          RegWrite = 1'b1;
          RegDst   = RD_RA;
          MemtoReg = M2R_PC;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = PCS_A;
        end
        S_TRAP:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control, checked per
// cycle against a step-table model of each instruction's lifetime.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic       ALUSrcA, Halted;
  logic [3:0] ALUOp;

  int n_pass = 0;
  int n_chk  = 0;

  multicycle_control #(.ALUOP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .Halted(Halted)
  );

  always #5 clk = ~clk;

  // Phases of an instruction's life, named by what the datapath does.
  localparam int P_FETCH = 0, P_DEC = 1, P_ADDR = 2, P_RD = 3;
  localparam int P_LDWB = 4, P_WR = 5, P_REX = 6, P_RWB = 7;
  localparam int P_IEX = 8, P_IWB = 9, P_BR = 10, P_J = 11;
  localparam int P_JAL = 12, P_JR = 13, P_HALT = 14;

  wire [19:0] obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite,
                     RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
                     ALUOp, PCSource, Halted};

  function automatic logic [19:0] pk(
    input logic pcw, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic rw,
    input logic [1:0] rd, input logic [1:0] m2r, input logic sa,
    input logic [1:0] sb, input logic [3:0] aop,
    input logic [1:0] pcs, input logic h);
    return {pcw, iord, mr, mw, irw, rw, rd, m2r, sa, sb, aop, pcs, h};
  endfunction

  function automatic logic [19:0] expect_of(
    input int p, input logic [5:0] op, input logic z,
    input logic rdy);
    logic [3:0] iop;
    iop = (op == 6'h0D) ? 4'd2 : (op == 6'h0C) ? 4'd3 :
          (op == 6'h0F) ? 4'd4 : 4'd0;
    case (p)
      P_FETCH: return pk(rdy,0,1,0,rdy,0,0,0,0,1,0,0,0);
      P_DEC:   return pk(0,0,0,0,0,0,0,0,0,3,0,0,0);
      P_ADDR:  return pk(0,0,0,0,0,0,0,0,1,2,0,0,0);
      P_RD:    return pk(0,1,1,0,0,0,0,0,0,0,0,0,0);
      P_LDWB:  return pk(0,0,0,0,0,1,0,1,0,0,0,0,0);
      P_WR:    return pk(0,1,0,1,0,0,0,0,0,0,0,0,0);
      P_REX:   return pk(0,0,0,0,0,0,0,0,1,0,7,0,0);
      P_RWB:   return pk(0,0,0,0,0,1,1,0,0,0,0,0,0);
      P_IEX:   return pk(0,0,0,0,0,0,0,0,1,2,iop,0,0);
      P_IWB:   return pk(0,0,0,0,0,1,0,0,0,0,0,0,0);
      P_BR:    return pk((op == 6'h04) ? z : !z,
                         0,0,0,0,0,0,0,1,0,1,1,0);
      P_J:     return pk(1,0,0,0,0,0,0,0,0,0,0,2,0);
      P_JAL:   return pk(1,0,0,0,0,1,2,2,0,0,0,2,0);
      P_JR:    return pk(1,0,0,0,0,0,0,0,0,0,0,3,0);
      default: return pk(0,0,0,0,0,0,0,0,0,0,0,0,1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'($urandom);
    #1 chk("reset_outputs", 20'h0);
    @(negedge clk);
    MemReady = 1'b1;
    #1 chk("reset_held", 20'h0);
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    Opcode = 6'($urandom);
    #1 chk("post_reset_fetch", expect_of(P_FETCH, 6'h0, 1'b0, 1'b0));
  endtask

  // fw/mw: wait cycles in fetch / data access (-1 = random 0..2).
  // abort_wr: assert reset during the first write-wait cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw,
                           input bit abort_wr);
    int ph[$];
    int nw;
    logic rdy;
    ph = '{P_FETCH, P_DEC};
    case (op)
      6'h00:   if (fn == 6'h08) ph.push_back(P_JR);
               else begin ph.push_back(P_REX); ph.push_back(P_RWB); end
      6'h23:   begin ph.push_back(P_ADDR); ph.push_back(P_RD);
                     ph.push_back(P_LDWB); end
      6'h2B:   begin ph.push_back(P_ADDR); ph.push_back(P_WR); end
      6'h08, 6'h0C, 6'h0D, 6'h0F:
               begin ph.push_back(P_IEX); ph.push_back(P_IWB); end
      6'h04, 6'h05: ph.push_back(P_BR);
      6'h02:   ph.push_back(P_J);
      6'h03:   ph.push_back(P_JAL);
      default: for (int k = 0; k < 20; k++) ph.push_back(P_HALT);
    endcase
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH) nw = (fw < 0) ? $urandom_range(0, 2) : fw;
      else if (ph[i] == P_RD || ph[i] == P_WR)
        nw = (mw < 0) ? $urandom_range(0, 2) : mw;
      else nw = 0;
      for (int w = 0; w <= nw; w++) begin
        @(negedge clk);
        rdy = (ph[i] == P_FETCH || ph[i] == P_RD || ph[i] == P_WR) ?
              (w == nw) : 1'($urandom);
        MemReady = rdy;
        Zero = (ph[i] == P_BR) ? z : 1'($urandom);
        if (ph[i] == P_FETCH) Opcode = 6'($urandom);
        else begin Opcode = op; Funct = fn; end
        #1 chk($sformatf("op%02h_ph%0d_w%0d", op, ph[i], w),
               expect_of(ph[i], op, z, rdy));
        if (abort_wr && ph[i] == P_WR) begin
          #2 reset = 1'b1;
          #1 chk("abort_write_drop", 20'h0);
          return;
        end
      end
    end
  endtask

  logic [5:0] legal_op [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h0C, 6'h0F, 6'h23, 6'h2B,
    6'h04, 6'h05};
  logic [5:0] legal_fn [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27,
    6'h00, 6'h02, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h00};

  initial begin
    int idx;
    do_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 2, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 1, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 2, 0, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
    do_reset();
    run_instr(6'h2B, 6'h00, 1'b0, 0, 2, 1'b1);
    @(negedge clk);
    MemReady = 1'b1;
    #1 chk("abort_write_held", 20'h0);
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1 chk("abort_then_fetch", expect_of(P_FETCH, 6'h0, 1'b0, 1'b0));
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        run_instr(6'h3E, 6'h00, 1'b0, -1, -1, 1'b0);
        do_reset();
      end else begin
        idx = $urandom_range(0, 17);
        if (idx == 16)
          run_instr(6'h02, 6'h00, 1'b0, -1, -1, 1'b0);
        else if (idx == 17)
          run_instr(6'h03, 6'h00, 1'b0, -1, -1, 1'b0);
        else
          run_instr(legal_op[idx], legal_fn[idx], 1'($urandom),
                    -1, -1, 1'b0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
